// File: rtl/mlm_link_arb.sv
// Round-robin arbiter that shares one Hamming(21,16) link among NREQ requesters,
// tracks words through the 2-cycle link, and halts after THRESH link errors.
module mlm_link_arb #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int CNTW   = 8,
    parameter int THRESH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [15:0]          enc_d,
    input  logic [4:0]           dec_syn,
    input  logic [15:0]          dec_q,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [15:0]          resp_data,
    output logic                 resp_corr,
    output logic                 resp_unc,
    output logic [CNTW-1:0]      err_cnt,
    output logic                 halted,
    input  logic                 clr_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW-1:0] THRESH_C = CNTW'(THRESH);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic            run_ok;
    logic            s0_valid;
    logic [IDW-1:0]  s0_id;
    logic            s1_valid;
    logic [IDW-1:0]  s1_id;
    logic            s1_corr;
    logic            s1_unc;
    logic [15:0]     data_hold;
    logic            inc;
    logic [CNTW-1:0] cnt_next;

    // Two ascending passes: indices above the pointer first, then wrap to 0..ptr.
    always_comb begin
        run_ok    = !rst && (state == RUN);
        grant_any = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (run_ok && !grant_any && req_valid[i] && (IDW'(i) > ptr)) begin
                grant_any = 1'b1;
                grant_id  = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (run_ok && !grant_any && req_valid[i] && (IDW'(i) <= ptr)) begin
                grant_any = 1'b1;
                grant_id  = IDW'(i);
            end
        end
        req_ready = '0;
        enc_d     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_any && (grant_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
                enc_d        = req_data[i*16 +: 16];
            end
        end
    end

    // A clear landing on an error response leaves exactly that one error counted.
    always_comb begin
        inc = s1_valid && (s1_corr || s1_unc);
        if (clr_cnt)
            cnt_next = inc ? CNTW'(1) : '0;
        else if (inc && (err_cnt != CNT_MAX))
            cnt_next = err_cnt + 1'b1;
        else
            cnt_next = err_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            halted    <= 1'b0;
            ptr       <= IDW'(NREQ - 1);
            s0_valid  <= 1'b0;
            s0_id     <= '0;
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_corr   <= 1'b0;
            s1_unc    <= 1'b0;
            data_hold <= '0;
            err_cnt   <= '0;
        end else begin
            s0_valid <= grant_any;
            if (grant_any) begin
                s0_id <= grant_id;
                ptr   <= grant_id;
            end
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_id   <= s0_id;
                s1_corr <= (dec_syn != 5'd0) && (dec_syn <= 5'd21);
                s1_unc  <= (dec_syn >= 5'd22);
            end
            if (s1_valid)
                data_hold <= dec_q;
            err_cnt <= cnt_next;
            case (state)
                RUN: begin
                    if (inc && (cnt_next == THRESH_C))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!s0_valid && !s1_valid) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (clr_cnt) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // Decoded data is taken straight from the link in its valid cycle, then held.
    assign resp_valid = s1_valid;
    assign resp_id    = s1_id;
    assign resp_corr  = s1_corr;
    assign resp_unc   = s1_unc;
    assign resp_data  = s1_valid ? dec_q : data_hold;

endmodule

// File: doc/mlm_link_arb.md
Name: mlm_link_arb

Overview:
- Round-robin arbiter and sequencer that shares one Hamming(21,16) encode/decode link (1-cycle encoder register, 1-cycle decoder register) among NREQ requesters.
- Issues one 16-bit word per cycle into the encoder and tracks in-flight words through the 2-cycle link latency.
- Returns each decoded word tagged with its requester ID and error status.
- Counts link errors and halts issue once a programmable threshold is reached, until software clears the count.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, equal to clog2(NREQ).
- CNTW, 8, error counter width.
- THRESH, 16, error count that forces halt (1..2^CNTW-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*16  per-requester word; requester k occupies bits [16k +: 16]
- req_ready  out  NREQ  one-hot grant; word accepted when valid&ready
- enc_d  out  16  word to encoder
- dec_syn  in  5  decoder syndrome {e4..e0}, valid 1 cycle after issue
- dec_q  in  16  corrected decoder output, valid 2 cycles after issue
- resp_valid  out  1  response strobe
- resp_id  out  IDW  requester ID of response
- resp_data  out  16  decoded word
- resp_corr  out  1  syndrome was 1..21 (single-bit error corrected)
- resp_unc  out  1  syndrome was 22..31 (invalid position, uncorrectable)
- err_cnt  out  CNTW  saturating count of corr+unc responses
- halted  out  1  arbiter in HALT state
- clr_cnt  in  1  pulse: zero err_cnt, release HALT

Behaviour:
- Reset values:
  - req_ready=0, enc_d=0, resp_valid=0, resp_id=0, resp_data=0, resp_corr=0, resp_unc=0.
  - err_cnt=0, halted=0, state=RUN, RR pointer=NREQ-1 (requester 0 has first priority).
  - Stage valid bits cleared.
  - Reset mid-operation discards all in-flight words; no responses are produced for them.
- Arbitration:
  - req_ready is combinational, at most one bit high, and only in RUN.
  - Grant goes to the first valid requester after the pointer, searching upward and wrapping from NREQ-1 to 0.
  - The pointer updates to the granted index on each accepted word only; with no grant it holds.
- Issue (cycle t):
  - enc_d = granted req_data, otherwise 0.
  - Stage0 registers {valid, id}.
- Cycle t+1:
  - Stage1 captures stage0 plus syn = dec_syn.
  - corr = syn in 1..21; unc = syn in 22..31; syn = 0 means clean.
  - dec_syn is ignored when stage0 is invalid.
- Cycle t+2:
  - resp_valid=1 with resp_id, resp_corr, resp_unc from stage1, and resp_data = dec_q sampled that cycle.
  - Otherwise resp_valid=0; resp_* other than valid hold their last values.
  - Throughput is 1 word/cycle; latency from accept to resp_valid is 2 cycles.
- err_cnt:
  - Increments by 1 in the cycle resp_valid is high with (corr|unc).
  - Saturates at 2^CNTW-1.
  - If clr_cnt is high in the same cycle: err_cnt = 1 when incrementing, else 0.
- FSM:
  - RUN -> DRAIN when the increment makes err_cnt == THRESH.
    - The word granted in that same cycle is still accepted.
  - DRAIN: no grants. In-flight words complete and still count.
    - -> HALT when both stage valids are 0.
    - clr_cnt in DRAIN clears the count, but the state still proceeds to HALT.
  - HALT: halted=1, no grants.
    - clr_cnt -> RUN next cycle with err_cnt=0.
  - clr_cnt in RUN only clears the count.
- Requester protocol:
  - A requester holds valid and data stable until accepted.
  - Dropping valid before grant is legal; no word is issued for it.

Test Plan:
1. Reset, then all 4 requesters valid with data 16'h1000+k, no errors -> grants 0,1,2,3,0... one per cycle. resp_id sequence 0,1,2,3 starting 2 cycles after the first accept, with resp_data matching. err_cnt=0.
2. Only requester 2 valid, back-to-back 16'hdead, 16'hbeef -> accepted on consecutive cycles. Responses are 2 cycles later with id=2, in order. Pointer stays at 2, so requester 3 then has priority when it raises valid.
3. Drive dec_syn=5'd3 on one word's syndrome cycle -> that response has resp_corr=1, resp_unc=0, err_cnt=1. dec_syn=5'd25 on another -> resp_unc=1, err_cnt=2.
4. THRESH=4 build, continuous traffic, syndrome 5'd7 on every word -> 4th error response moves FSM to DRAIN. Grants stop, 2 in-flight responses still arrive, err_cnt=6, halted=1. clr_cnt pulse -> err_cnt=0, grants resume next cycle.
5. clr_cnt asserted in the same cycle as an error response -> err_cnt=1. Force 300 errors with THRESH=255 and CNTW=8 -> halt occurs at 255, then err_cnt saturates at 255 and does not wrap.
6. Assert rst with 2 words in flight -> no resp_valid follows, err_cnt=0. After release, requester 0 is granted first.
